// File: rtl/uart_pkg.sv
// uart_pkg: shared receiver state encoding, frame constants and parity helper.
package uart_pkg;
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} rx_state_e;
   localparam int DATA_BITS = 8;
   localparam logic STOP_LEVEL = 1'b1;
   localparam logic IDLE_LEVEL = 1'b1;
   function automatic logic odd_parity(input logic [DATA_BITS-1:0] b);
      return ~^b;
   endfunction
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchronizer for the serial line, reset to idle level.
module uart_rx_sync (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);
   logic meta_q, sync_q;
   always_ff @(posedge clk) begin
      if (!rst) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end
   assign q_o = sync_q;
endmodule

// File: rtl/uart_rx_8o1.sv
// uart_rx_8o1: 8-O-1 UART receiver with mid-bit sampling, one-cycle valid strobe
// and parity/framing error flags.
module uart_rx_8o1
   import uart_pkg::*;
#(
   parameter int clk_freq  = 1000000,
   parameter int baud_rate = 9600
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       parity_err,
   output logic       frame_err,
   output logic       busy
);
   localparam int clks_per_bit = clk_freq / baud_rate;
   localparam int half_bit     = clks_per_bit / 2;
   localparam int CW           = $clog2(clks_per_bit);
   localparam logic [CW-1:0] CNT_HALF = CW'(half_bit - 1);
   localparam logic [CW-1:0] CNT_END  = CW'(clks_per_bit - 1);
   rx_state_e                state_q;
   logic [CW-1:0]            cnt_q;
   logic [2:0]               bit_idx_q;
   logic [DATA_BITS-1:0]     shift_q, shift_d, rx_data_q;
   logic                     par_q, rx_valid_q, parity_err_q, frame_err_q;
   logic                     rxs, at_end;
   uart_rx_sync u_sync (.clk(clk), .rst(rst), .d_i(rx), .q_o(rxs));
   assign shift_d = {rxs, shift_q[DATA_BITS-1:1]};
   assign at_end  = cnt_q == CNT_END;
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         bit_idx_q    <= '0;
         shift_q      <= '0;
         par_q        <= 1'b0;
         rx_data_q    <= '0;
         rx_valid_q   <= 1'b0;
         parity_err_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         rx_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               cnt_q <= '0;
               if (!rxs) state_q <= START;
            end
            START: begin
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CNT_HALF) begin
                  cnt_q     <= '0;
                  bit_idx_q <= '0;
                  state_q   <= rxs ? IDLE : DATA;
               end
            end
            DATA: begin
               cnt_q <= cnt_q + 1'b1;
               if (at_end) begin
                  cnt_q     <= '0;
                  shift_q   <= shift_d;
                  bit_idx_q <= bit_idx_q + 3'd1;
                  if (bit_idx_q == 3'd7) state_q <= PARITY;
               end
            end
            PARITY: begin
               cnt_q <= cnt_q + 1'b1;
               if (at_end) begin
                  cnt_q   <= '0;
                  par_q   <= rxs;
                  state_q <= STOP;
               end
            end
            STOP: begin
               cnt_q <= cnt_q + 1'b1;
               if (at_end) begin
                  cnt_q        <= '0;
                  rx_valid_q   <= 1'b1;
                  rx_data_q    <= shift_q;
                  parity_err_q <= par_q != odd_parity(shift_q);
                  frame_err_q  <= rxs != STOP_LEVEL;
                  state_q      <= (rxs == STOP_LEVEL) ? IDLE : WAIT_HIGH;
               end
            end
            // a held-low line (break) must not be decoded as a stream of frames
            WAIT_HIGH: if (rxs == IDLE_LEVEL) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end
   assign rx_data    = rx_data_q;
   assign rx_valid   = rx_valid_q;
   assign parity_err = parity_err_q;
   assign frame_err  = frame_err_q;
   assign busy       = state_q != IDLE;
endmodule

// File: tb/tb_uart_rx_8o1.sv
// tb_uart_rx_8o1: directed self-checking bench for the 8-O-1 receiver.
module tb_uart_rx_8o1;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       rx  = 1'b1;
   logic [7:0] rx_data;
   logic       rx_valid, parity_err, frame_err, busy;
   int         checks = 0;
   int         failures = 0;
   int         cyc = 0;
   logic [7:0] cap_d[$];
   logic       cap_p[$];
   logic       cap_f[$];
   int         cap_c[$];

   uart_rx_8o1 dut (
      .clk(clk), .rst(rst), .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid),
      .parity_err(parity_err), .frame_err(frame_err), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk)
      if (rx_valid === 1'b1) begin
         cap_d.push_back(rx_data);
         cap_p.push_back(parity_err);
         cap_f.push_back(frame_err);
         cap_c.push_back(cyc);
      end

   task automatic drive_bit(input logic b, input int n);
      rx = b;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input int bc);
      drive_bit(1'b0, bc);
      for (int i = 0; i < 8; i++) drive_bit(d[i], bc);
      drive_bit(p, bc);
      drive_bit(s, bc);
   endtask

   task automatic clear_caps();
      cap_d.delete(); cap_p.delete(); cap_f.delete(); cap_c.delete();
   endtask

   task automatic test_reset();
      rst = 1'b0;
      rx  = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", rx_data); end
      checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", rx_valid); end
      checks++; if (parity_err !== 1'b0 || frame_err !== 1'b0) begin failures++; $display("FAIL reset_errs got=%b%b exp=00", parity_err, frame_err); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
   endtask

   task automatic test_clean();
      logic [7:0] bytes [4] = '{8'hA5, 8'h00, 8'hFF, 8'h3C};
      logic       pars  [4] = '{1'b1, 1'b1, 1'b1, 1'b1};
      int t0;
      for (int i = 0; i < 4; i++) begin
         clear_caps();
         t0 = cyc;
         send_frame(bytes[i], pars[i], 1'b1, 106);
         drive_bit(1'b1, 20);
         checks++; if (cap_d.size() != 1) begin failures++; $display("FAIL clean_count[%0d] got=%0d exp=1", i, cap_d.size()); end
         if (cap_d.size() > 0) begin
            checks++; if (cap_d[0] !== bytes[i]) begin failures++; $display("FAIL clean_data[%0d] got=%h exp=%h", i, cap_d[0], bytes[i]); end
            checks++; if (cap_p[0] !== 1'b0 || cap_f[0] !== 1'b0) begin failures++; $display("FAIL clean_errs[%0d] got=%b%b exp=00", i, cap_p[0], cap_f[0]); end
            if (i == 0) begin
               checks++; if (cap_c[0] - t0 != 1095) begin failures++; $display("FAIL clean_latency got=%0d exp=1095", cap_c[0] - t0); end
            end
         end
      end
   endtask

   task automatic test_bad_parity();
      clear_caps();
      send_frame(8'h5A, 1'b0, 1'b1, 104);
      drive_bit(1'b1, 20);
      checks++; if (cap_d.size() != 1) begin failures++; $display("FAIL par_count got=%0d exp=1", cap_d.size()); end
      if (cap_d.size() > 0) begin
         checks++; if (cap_d[0] !== 8'h5A) begin failures++; $display("FAIL par_data got=%h exp=5a", cap_d[0]); end
         checks++; if (cap_p[0] !== 1'b1) begin failures++; $display("FAIL par_perr got=%b exp=1", cap_p[0]); end
         checks++; if (cap_f[0] !== 1'b0) begin failures++; $display("FAIL par_ferr got=%b exp=0", cap_f[0]); end
      end
   endtask

   task automatic test_frame_err();
      clear_caps();
      send_frame(8'h81, 1'b1, 1'b0, 104);
      drive_bit(1'b0, 2000);
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL break_busy got=%b exp=1", busy); end
      checks++; if (cap_d.size() != 1) begin failures++; $display("FAIL break_count got=%0d exp=1", cap_d.size()); end
      if (cap_d.size() > 0) begin
         checks++; if (cap_d[0] !== 8'h81) begin failures++; $display("FAIL break_data got=%h exp=81", cap_d[0]); end
         checks++; if (cap_f[0] !== 1'b1 || cap_p[0] !== 1'b0) begin failures++; $display("FAIL break_errs got=p%b f%b exp=p0 f1", cap_p[0], cap_f[0]); end
      end
      drive_bit(1'b1, 30);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL break_idle got=%b exp=0", busy); end
      checks++; if (cap_d.size() != 1) begin failures++; $display("FAIL break_extra got=%0d exp=1", cap_d.size()); end
   endtask

   task automatic test_glitch();
      clear_caps();
      drive_bit(1'b0, 20);
      drive_bit(1'b1, 25);
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL glitch_busy_mid got=%b exp=1", busy); end
      drive_bit(1'b1, 20);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL glitch_busy_end got=%b exp=0", busy); end
      drive_bit(1'b1, 1200);
      checks++; if (cap_d.size() != 0) begin failures++; $display("FAIL glitch_valid got=%0d exp=0", cap_d.size()); end
   endtask

   task automatic test_reset_mid();
      logic [7:0] d = 8'hC3;
      clear_caps();
      drive_bit(1'b0, 104);
      for (int i = 0; i < 3; i++) drive_bit(d[i], 104);
      drive_bit(d[3], 52);
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rstmid_busy_before got=%b exp=1", busy); end
      rst = 1'b0;
      rx  = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      checks++; if (rx_data !== 8'h00 || rx_valid !== 1'b0 || parity_err !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0) begin
         failures++; $display("FAIL rstmid_outputs got=data%h v%b p%b f%b b%b exp=all0", rx_data, rx_valid, parity_err, frame_err, busy);
      end
      drive_bit(1'b1, 1200);
      checks++; if (cap_d.size() != 0) begin failures++; $display("FAIL rstmid_valid got=%0d exp=0", cap_d.size()); end
      send_frame(8'h11, 1'b1, 1'b1, 104);
      drive_bit(1'b1, 20);
      checks++; if (cap_d.size() != 1) begin failures++; $display("FAIL rstmid_next_count got=%0d exp=1", cap_d.size()); end
      if (cap_d.size() > 0) begin
         checks++; if (cap_d[0] !== 8'h11 || cap_p[0] !== 1'b0 || cap_f[0] !== 1'b0) begin
            failures++; $display("FAIL rstmid_next got=%h p%b f%b exp=11 p0 f0", cap_d[0], cap_p[0], cap_f[0]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] bytes [10] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h0F, 8'hE7};
      clear_caps();
      for (int i = 0; i < 10; i++) send_frame(bytes[i], ~^bytes[i], 1'b1, 106);
      drive_bit(1'b1, 20);
      checks++; if (cap_d.size() != 10) begin failures++; $display("FAIL b2b_count got=%0d exp=10", cap_d.size()); end
      for (int i = 0; i < 10 && i < cap_d.size(); i++) begin
         checks++; if (cap_d[i] !== bytes[i] || cap_p[i] !== 1'b0 || cap_f[i] !== 1'b0) begin
            failures++; $display("FAIL b2b[%0d] got=%h p%b f%b exp=%h p0 f0", i, cap_d[i], cap_p[i], cap_f[i], bytes[i]);
         end
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      drive_bit(1'b1, 10);
      test_clean();
      test_bad_parity();
      test_frame_err();
      test_glitch();
      test_reset_mid();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
